// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
package mdu_pkg;

    // Default operand and HI/LO width; also the number of iterations.
    localparam int MDU_WIDTH = 32;

    // Operation encodings as presented on the Op port.
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } mdu_op_e;

    // Sequencer states.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10
    } mdu_state_e;

    // Signed operations run the unsigned core on operand magnitudes.
    function automatic logic op_is_signed(input mdu_op_e op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input mdu_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/mdu_iter_core.sv
// Unsigned iteration datapath: a 2*WIDTH-bit {hi,lo} register pair plus the
// multiplicand/divisor. Each step either does one shift-add (multiply, lo
// holds the shrinking multiplier) or one restoring shift-subtract (divide, lo
// holds the dividend shifting out and the quotient shifting in).
module mdu_iter_core
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             load,
    input  logic             step,
    input  logic             is_div,
    input  logic [WIDTH-1:0] load_a,
    input  logic [WIDTH-1:0] load_b,
    output logic [WIDTH-1:0] acc_hi,
    output logic [WIDTH-1:0] acc_lo
);

    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] b_q,  b_d;

    logic [WIDTH:0] sum;
    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // Datapath registers, cleared by the asynchronous reset.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            hi_q <= '0;
            lo_q <= '0;
            b_q  <= '0;
        end else begin
            hi_q <= hi_d;
            lo_q <= lo_d;
            b_q  <= b_d;
        end
    end

    // One iteration: load fresh operands, or advance multiply or divide by a bit.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        b_d  = b_q;
        // Carry-out lands in sum[WIDTH] and shifts down into hi.
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        // Partial remainder always stays below the divisor, so WIDTH+1 bits suffice.
        shifted = {hi_q, lo_q[WIDTH-1]};
        diff    = shifted - {1'b0, b_q};
        if (load) begin
            hi_d = '0;
            lo_d = load_a;
            b_d  = load_b;
        end else if (step) begin
            if (is_div) begin
                if (!diff[WIDTH]) begin
                    hi_d = diff[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_d = shifted[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                hi_d = sum[WIDTH:1];
                lo_d = {sum[0], lo_q[WIDTH-1:1]};
            end
        end
    end

    assign acc_hi = hi_q;
    assign acc_lo = lo_q;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Sequencing, sign handling, divide-by-zero results and MTHI/MTLO live here;
// the unsigned per-bit arithmetic lives in mdu_iter_core.
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    input  logic             HiWrite,
    input  logic             LoWrite,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam int CNT_W = $clog2(WIDTH);

    mdu_state_e       state_q, state_d;
    mdu_op_e          op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             neg_q, neg_d;          // product / quotient negation
    logic             rem_neg_q, rem_neg_d;  // remainder follows dividend sign
    logic             div_zero_q, div_zero_d;
    logic [WIDTH-1:0] dividend_q, dividend_d; // original OperandA for x/0
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    mdu_op_e          op_in;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             core_load, core_step;
    logic [WIDTH-1:0] core_hi, core_lo;
    logic [2*WIDTH-1:0] prod_raw, prod_fix;
    logic [WIDTH-1:0] quot_fix, rem_fix;

    mdu_iter_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .Clock  (Clock),
        .Reset  (Reset),
        .load   (core_load),
        .step   (core_step),
        .is_div (op_is_div(op_q)),
        .load_a (a_mag),
        .load_b (b_mag),
        .acc_hi (core_hi),
        .acc_lo (core_lo)
    );

    // Control and architectural registers; reset aborts any operation in flight.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            op_q       <= OP_MULT;
            cnt_q      <= '0;
            neg_q      <= 1'b0;
            rem_neg_q  <= 1'b0;
            div_zero_q <= 1'b0;
            dividend_q <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            cnt_q      <= cnt_d;
            neg_q      <= neg_d;
            rem_neg_q  <= rem_neg_d;
            div_zero_q <= div_zero_d;
            dividend_q <= dividend_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            done_q     <= done_d;
        end
    end

    // Sequencer: accept work or MT writes in IDLE, iterate WIDTH times, then fix signs.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        cnt_d      = cnt_q;
        neg_d      = neg_q;
        rem_neg_d  = rem_neg_q;
        div_zero_d = div_zero_q;
        dividend_d = dividend_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        done_d     = 1'b0;
        core_load  = 1'b0;
        core_step  = 1'b0;

        op_in = mdu_op_e'(Op);
        a_neg = op_is_signed(op_in) & OperandA[WIDTH-1];
        b_neg = op_is_signed(op_in) & OperandB[WIDTH-1];
        a_mag = a_neg ? -OperandA : OperandA;
        b_mag = b_neg ? -OperandB : OperandB;

        prod_raw = {core_hi, core_lo};
        prod_fix = neg_q ? -prod_raw : prod_raw;
        quot_fix = neg_q ? -core_lo : core_lo;
        rem_fix  = rem_neg_q ? -core_hi : core_hi;

        case (state_q)
            S_IDLE: begin
                if (HiWrite) hi_d = OperandA;
                if (LoWrite) lo_d = OperandA;
                if (Start) begin
                    op_d       = op_in;
                    neg_d      = a_neg ^ b_neg;
                    rem_neg_d  = a_neg;
                    div_zero_d = (OperandB == '0);
                    dividend_d = OperandA;
                    cnt_d      = '0;
                    core_load  = 1'b1;
                    state_d    = S_CALC;
                end
            end
            S_CALC: begin
                core_step = 1'b1;
                cnt_d     = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (op_is_div(op_q)) begin
                    if (div_zero_q) begin
                        lo_d = '1;
                        hi_d = dividend_q;
                    end else begin
                        lo_d = quot_fix;
                        hi_d = rem_fix;
                    end
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign Busy = (state_q != S_IDLE);
    assign Done = done_q;
    assign Hi   = hi_q;
    assign Lo   = lo_q;

endmodule
